muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-002 SHALL have resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have start, input, 1, execute-stage request to begin the operation selected by op.
REQ-004 SHALL have op, input, 2, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have a, input, 32, forwarded rs value (dividend / multiplicand).
REQ-006 SHALL have b, input, 32, forwarded rt value (divisor / multiplier).
REQ-007 SHALL have flush, input, 1, abort the in-flight operation.
REQ-008 SHALL have hi_we, lo_we, input, 1 each; wdata, input, 32; these are the MTHI/MTLO writes.
REQ-009 SHALL have stall, output, 1, execute-stage stall request.
REQ-010 SHALL have done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have hi, lo, output, 32 each, the architectural HI/LO registers.

Function
REQ-012 SHALL implement FSM states IDLE and BUSY, plus a 6-bit iteration counter.
REQ-013 SHALL capture a, b and op at the rising edge where state is IDLE, start=1, done=0 and flush=0 (edge E0).
- For multi-cycle ops it SHALL then enter BUSY with counter 0.
REQ-014 SHALL, in BUSY, perform exactly one iteration per cycle.
- After 32 iterations (edge E32) it SHALL write hi/lo, return to IDLE, and drive done=1 for the following cycle only.
REQ-015 SHALL drive stall = (IDLE & start & ~done & multi-cycle op) | BUSY, combinationally.
REQ-016 SHALL ignore start in any cycle where done=1, so a held request never restarts.
REQ-017 SHALL compute DIV/DIVU by restoring division on operand magnitudes.
- DIV: quotient is negated when the operand signs differ; remainder takes the dividend's sign.
- LO = quotient, HI = remainder.
REQ-018 SHALL handle divide by zero (b=0) in one cycle with no BUSY: at E0 write HI=a, LO=32'hFFFFFFFF; done follows.
REQ-019 SHALL compute MULT/MULTU as the full 64-bit product: HI = bits 63:32, LO = bits 31:0; MULT is signed.
REQ-020 SHALL, on flush=1, return to IDLE at the next edge with hi/lo unchanged and no done pulse; flush overrides start.
REQ-021 SHALL, when IDLE, apply hi_we/lo_we at the edge.
- An operation completing at the same edge takes priority over hi_we/lo_we.
- hi_we/lo_we are ignored in BUSY.
REQ-022 SHALL keep hi/lo stable except on completion or an MTHI/MTLO write.

Reset
REQ-023 SHALL, while resetn=0, force immediately: state IDLE, counter 0, hi=0, lo=0, done=0, internal operand registers 0; stall follows REQ-015.
REQ-024 SHALL, on reset asserted mid-operation, discard the operation with no done pulse after release.

Configuration
REQ-025 SHALL honour macro MULDIV_FAST_MULT_EN.
- Defined: MULT/MULTU complete single-cycle; hi/lo are written at E0, done=1 in the next cycle, stall is never asserted for multiply.
- Undefined: MULT/MULTU use 32-iteration shift-add, with timing identical to REQ-014 and stall per REQ-015.
- Division is unaffected either way.

Verification
REQ-026 SHALL be verified with DIVU a=100, b=7: stall for 33 cycles, then done; LO=14, HI=2.
REQ-027 SHALL be verified with DIV a=-7 (32'hFFFFFFF9), b=2: LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1).
REQ-028 SHALL be verified with MULT a=32'hFFFFFFFF, b=2: HI=32'hFFFFFFFF, LO=32'hFFFFFFFE.
- Macro defined: done 1 cycle after E0.
- Macro undefined: done 33 cycles after E0.
REQ-029 SHALL be verified with DIVU a=5, b=0: no BUSY; HI=5, LO=32'hFFFFFFFF; done one cycle after E0.
REQ-030 SHALL be verified with flush asserted at counter 10 of a DIV, with HI/LO preloaded to 1/2 via hi_we/lo_we: returns IDLE, HI=1, LO=2, no done.
REQ-031 SHALL be verified with start held high through done while resetn pulses low mid-DIV:
- Outputs are zero during reset; no done after release.
- Held start through done causes no second operation.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake plus HI/LO read/write bus for muldiv_unit.
interface muldiv_unit_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        flush;
   logic        hi_we;
   logic        lo_we;
   logic [31:0] wdata;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (output start, op, a, b, flush, hi_we, lo_we, wdata,
                   input  stall, done, hi, lo);
   modport slave  (input  start, op, a, b, flush, hi_we, lo_we, wdata,
                   output stall, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// MIPS-style HI/LO multiply/divide unit: 32-step shift-add multiply, restoring divide.
// Define MULDIV_FAST_MULT_EN for a single-cycle MULT/MULTU; division is unaffected.
module muldiv_unit (
   input logic          clk,
   input logic          resetn,
   muldiv_unit_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] acc_hi_q, acc_hi_d;
   logic [31:0] acc_lo_q, acc_lo_d;
   logic [31:0] opb_q, opb_d;
   logic        is_div_q, is_div_d;
   logic        neg_q_q, neg_q_d;
   logic        neg_r_q, neg_r_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;
   logic        stall;

   // Request decode: op[1] selects divide, op[0]=0 selects the signed form.
   logic        is_div_in, signed_in, sa, sb, div0, multi_in, accept;
   logic [31:0] mag_a, mag_b;

   assign is_div_in = bus.op[1];
   assign signed_in = ~bus.op[0];
   assign sa        = signed_in & bus.a[31];
   assign sb        = signed_in & bus.b[31];
   assign mag_a     = sa ? (32'd0 - bus.a) : bus.a;
   assign mag_b     = sb ? (32'd0 - bus.b) : bus.b;
   assign div0      = is_div_in & (bus.b == 32'd0);
`ifdef MULDIV_FAST_MULT_EN
   assign multi_in  = is_div_in & ~div0;
   logic [63:0] fast_prod;
   assign fast_prod = $signed({{32{sa}}, bus.a}) * $signed({{32{sb}}, bus.b});
`else
   assign multi_in  = ~div0;
`endif
   // A done cycle masks start so a request held through completion is not re-run.
   assign accept    = (state_q == IDLE) & bus.start & ~done_q & ~bus.flush;

   // One iteration: acc_hi is the partial product / running remainder,
   // acc_lo the multiplier / dividend being shifted out.
   logic [32:0] sum33, shl33, madd;
   logic        ge;
   logic [31:0] it_hi, it_lo;
   logic [63:0] prod_mag, prod_res;
   logic [31:0] quo, rem, fin_hi, fin_lo;

   always_comb begin
      sum33 = {1'b0, acc_hi_q} + {1'b0, opb_q};
      shl33 = {acc_hi_q, acc_lo_q[31]};
      ge    = (shl33 >= {1'b0, opb_q});
      madd  = acc_lo_q[0] ? sum33 : {1'b0, acc_hi_q};
      if (is_div_q) begin
         it_hi = ge ? (shl33[31:0] - opb_q) : shl33[31:0];
         it_lo = {acc_lo_q[30:0], ge};
      end else begin
         it_hi = madd[32:1];
         it_lo = {madd[0], acc_lo_q[31:1]};
      end
      prod_mag = {it_hi, it_lo};
      prod_res = neg_q_q ? (64'd0 - prod_mag) : prod_mag;
      quo      = neg_q_q ? (32'd0 - it_lo) : it_lo;
      rem      = neg_r_q ? (32'd0 - it_hi) : it_hi;
      fin_hi   = is_div_q ? rem : prod_res[63:32];
      fin_lo   = is_div_q ? quo : prod_res[31:0];
   end

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept && multi_in) state_d = BUSY;
         BUSY:    if (bus.flush || cnt_q == 6'd31) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      stall = (state_q == BUSY) |
              ((state_q == IDLE) & bus.start & ~done_q & multi_in);
   end

   // Datapath and architectural registers
   always_comb begin
      cnt_d    = cnt_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      opb_d    = opb_q;
      is_div_d = is_div_q;
      neg_q_d  = neg_q_q;
      neg_r_d  = neg_r_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      if (state_q == IDLE) begin
         if (accept && multi_in) begin
            cnt_d    = 6'd0;
            is_div_d = is_div_in;
            neg_q_d  = sa ^ sb;
            neg_r_d  = sa;
            acc_hi_d = 32'd0;
            acc_lo_d = is_div_in ? mag_a : mag_b;
            opb_d    = is_div_in ? mag_b : mag_a;
         end else if (accept) begin
            // Single-cycle completion beats a coincident MTHI/MTLO.
            done_d = 1'b1;
`ifdef MULDIV_FAST_MULT_EN
            if (!is_div_in) begin
               hi_d = fast_prod[63:32];
               lo_d = fast_prod[31:0];
            end else
`endif
            begin
               hi_d = bus.a;
               lo_d = 32'hFFFF_FFFF;
            end
         end else begin
            if (bus.hi_we) hi_d = bus.wdata;
            if (bus.lo_we) lo_d = bus.wdata;
         end
      end else if (bus.flush) begin
         cnt_d = 6'd0;
      end else begin
         acc_hi_d = it_hi;
         acc_lo_d = it_lo;
         cnt_d    = cnt_q + 6'd1;
         if (cnt_q == 6'd31) begin
            cnt_d  = 6'd0;
            hi_d   = fin_hi;
            lo_d   = fin_lo;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q    <= 6'd0;
         acc_hi_q <= 32'd0;
         acc_lo_q <= 32'd0;
         opb_q    <= 32'd0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         done_q   <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         opb_q    <= opb_d;
         is_div_q <= is_div_d;
         neg_q_q  <= neg_q_d;
         neg_r_q  <= neg_r_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign bus.stall = stall;
   assign bus.done  = done_q;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, stall count and HI/LO results per vector.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   muldiv_unit_if bus();

   muldiv_unit dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

`ifdef MULDIV_FAST_MULT_EN
   localparam int MUL_LAT = 1;
   localparam int MUL_STL = 0;
`else
   localparam int MUL_LAT = 33;
   localparam int MUL_STL = 33;
`endif

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // mode: 0 plain, 1 MTHI/MTLO during BUSY, 2 MTHI/MTLO alongside start, 3 hold start through done
   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input int exp_lat, input int exp_stl, input int mode);
      int  stl = 0;
      int  lat = 0;
      bit  seen = 0;
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
      if (mode == 2) begin bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hDEAD; end
      #1 if (bus.stall) stl++;
      @(posedge clk);
      #1;
      if (mode != 3) bus.start = 1'b0;
      bus.hi_we = 1'b0; bus.lo_we = 1'b0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (mode == 1 && i == 5) begin bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hBEEF; end
         if (mode == 1 && i == 6) begin bus.hi_we = 1'b0; bus.lo_we = 1'b0; end
         #1;
         if (bus.stall) stl++;
         if (bus.done) begin lat = i; seen = 1; break; end
      end
      chk({tag, "_lat"}, seen ? lat : -1, exp_lat);
      chk({tag, "_stall"}, stl, exp_stl);
      chk({tag, "_hi"}, bus.hi, exp_hi);
      chk({tag, "_lo"}, bus.lo, exp_lo);
      if (mode == 3) begin
         chk({tag, "_stall_done"}, bus.stall, 1'b0);
         @(posedge clk);
         #1 bus.start = 1'b0;
         @(negedge clk);
         chk({tag, "_no_restart"}, bus.stall, 1'b0);
      end
      bus.hi_we = 1'b0; bus.lo_we = 1'b0;
   endtask

   task automatic no_done(input string tag, input int cycles);
      int cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (bus.done || bus.stall) cnt++;
      end
      chk(tag, cnt, 0);
   endtask

   initial begin
      bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
      bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_hi", bus.hi, 0);
      chk("rst_lo", bus.lo, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_stall", bus.stall, 0);
      resetn = 1'b1;

      run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, 33, 0);
      run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 33, 0);
      run_op("div_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 33, 33, 0);
      run_op("div_min_m1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 33, 0);
      run_op("mult_m1_2", 2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, MUL_STL, 0);
      run_op("multu_ff_2", 2'b01, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, MUL_LAT, MUL_STL, 0);
      run_op("mult_m3_5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MUL_LAT, MUL_STL, 0);
      run_op("mult_min_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, MUL_LAT, MUL_STL, 0);
      run_op("divu_5_0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1, 0, 0);
      run_op("div0_vs_mt", 2'b10, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1, 0, 2);
      run_op("busy_mt_ign", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 33, 33, 1);

      // MTHI/MTLO preload, then flush a DIV at counter 10
      @(negedge clk); bus.hi_we = 1'b1; bus.wdata = 32'd1;
      @(negedge clk); bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'd2;
      @(negedge clk); bus.lo_we = 1'b0;
      chk("mt_hi", bus.hi, 32'd1);
      chk("mt_lo", bus.lo, 32'd2);
      bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd1000; bus.b = 32'd3;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk); bus.flush = 1'b1;
      @(negedge clk); bus.flush = 1'b0;
      chk("flush_idle", bus.stall, 1'b0);
      chk("flush_hi", bus.hi, 32'd1);
      chk("flush_lo", bus.lo, 32'd2);
      no_done("flush_no_done", 40);

      // Start held through done: exactly one operation
      run_op("held_start", 2'b11, 32'd9, 32'd2, 32'd1, 32'd4, 33, 33, 3);
      no_done("held_no_second", 40);

      // Reset mid-DIV with start held, then discarded
      @(negedge clk);
      bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd100; bus.b = 32'd7;
      @(posedge clk);
      repeat (5) @(negedge clk);
      chk("mid_busy", bus.stall, 1'b1);
      resetn = 1'b0; bus.start = 1'b0;
      #1;
      chk("mid_rst_hi", bus.hi, 0);
      chk("mid_rst_lo", bus.lo, 0);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_stall", bus.stall, 0);
      @(negedge clk); resetn = 1'b1;
      no_done("rst_no_done", 40);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
